imm_pipe: RTL and testbench

Multi-lane, pipelined immediate generator for the superscalar decode stage. Each accepted bundle holds up to LANES 32-bit RISC-V instructions plus per-lane format selects; the block extracts and sign-/zero-extends the immediates to XLEN. Results leave through a registered valid/ready port backed by a 2-entry skid buffer, so back-pressure never drops or reorders bundles. Sits between fetch-buffer output and the decode/ID pipeline register.

---
 rtl/imm_pipe_pkg.sv | 37 +++
 rtl/imm_pipe_lane.sv | 63 ++++++
 rtl/imm_pipe.sv | 102 ++++++++++
 tb/tb_imm_pipe.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/imm_pipe_pkg.sv
// imm_pkg: shared select encodings, RISC-V opcode constants and skid-buffer
// state encoding for the imm_pipe immediate generator.
package imm_pkg;

  typedef enum logic [2:0] {
    IMM_I   = 3'b000,
    IMM_S   = 3'b001,
    IMM_B   = 3'b010,
    IMM_U   = 3'b011,
    IMM_J   = 3'b100,
    IMM_R   = 3'b101,
    IMM_Z   = 3'b110,
    IMM_ILL = 3'b111
  } imm_sel_t;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_OP     = 7'b0110011;

  // Skid buffer occupancy:
  // state    | meaning
  // ST_EMPTY | no valid entry
  // ST_ONE   | main register M valid
  // ST_FULL  | M and skid register K valid
  typedef logic [1:0] imm_state_t;
  localparam imm_state_t ST_EMPTY = 2'd0;
  localparam imm_state_t ST_ONE   = 2'd1;
  localparam imm_state_t ST_FULL  = 2'd2;

endpackage

// File: rtl/imm_pipe_lane.sv
// imm_lane: combinational immediate extraction for one instruction lane.
// With IMM_PIPE_DECODE_EN defined the format select comes from the opcode
// and the sel input is ignored; otherwise sel is used as given.
import imm_pkg::*;

module imm_lane #(
  parameter int XLEN = 32
) (
  input  logic [31:0]     instr,
  input  logic [2:0]      sel,
  input  logic            en,
  output logic [XLEN-1:0] imm,
  output logic            err
);

  imm_sel_t sel_eff;
  logic     s;

  assign s = instr[31];

`ifdef IMM_PIPE_DECODE_EN
  logic [2:0] unused_sel;
  assign unused_sel = sel;

  // Derive the format from the opcode; CSR-immediate forms have funct3[2] set.
  always_comb begin
    sel_eff = IMM_ILL;
    case (instr[6:0])
      OP_LOAD, OP_IMM, OP_JALR: sel_eff = IMM_I;
      OP_SYSTEM:                sel_eff = instr[14] ? IMM_Z : IMM_I;
      OP_STORE:                 sel_eff = IMM_S;
      OP_BRANCH:                sel_eff = IMM_B;
      OP_LUI, OP_AUIPC:         sel_eff = IMM_U;
      OP_JAL:                   sel_eff = IMM_J;
      OP_OP:                    sel_eff = IMM_R;
      default:                  sel_eff = IMM_ILL;
    endcase
  end
`else
  logic unused_opcode;
  assign unused_opcode = ^instr[6:0];
  assign sel_eff = imm_sel_t'(sel);
`endif

  // Assemble and extend the immediate; a disabled lane reports nothing.
  always_comb begin
    imm = '0;
    err = 1'b0;
    if (en) begin
      case (sel_eff)
        IMM_I:   imm = {{(XLEN-11){s}}, instr[30:20]};
        IMM_S:   imm = {{(XLEN-11){s}}, instr[30:25], instr[11:7]};
        IMM_B:   imm = {{(XLEN-12){s}}, instr[7], instr[30:25], instr[11:8], 1'b0};
        IMM_U:   imm = {{(XLEN-31){s}}, instr[30:12], 12'b0};
        IMM_J:   imm = {{(XLEN-20){s}}, instr[19:12], instr[20], instr[30:21], 1'b0};
        IMM_Z:   imm = {{(XLEN-5){1'b0}}, instr[19:15]};
        IMM_R:   imm = '0;
        default: err = 1'b1;
      endcase
    end
  end

endmodule

// File: rtl/imm_pipe.sv
// imm_pipe: multi-lane immediate generator with a registered valid/ready
// output backed by a two-entry skid buffer (main M, skid K).
// Optional opcode-based select derivation: define IMM_PIPE_DECODE_EN.
import imm_pkg::*;

module imm_pipe #(
  parameter int XLEN  = 32,
  parameter int LANES = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [LANES*32-1:0]   in_instr,
  input  logic [LANES*3-1:0]    in_sel,
  input  logic [LANES-1:0]      in_lane_en,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [LANES*XLEN-1:0] out_imm,
  output logic [LANES-1:0]      out_lane_en,
  output logic [LANES-1:0]      out_err
);

  logic [LANES*XLEN-1:0] new_imm;
  logic [LANES-1:0]      new_err;

  for (genvar g = 0; g < LANES; g++) begin : g_lane
    imm_lane #(.XLEN(XLEN)) u_lane (
      .instr (in_instr[g*32 +: 32]),
      .sel   (in_sel[g*3 +: 3]),
      .en    (in_lane_en[g]),
      .imm   (new_imm[g*XLEN +: XLEN]),
      .err   (new_err[g])
    );
  end

  imm_state_t            state;
  logic [LANES*XLEN-1:0] m_imm, k_imm;
  logic [LANES-1:0]      m_en, k_en, m_err, k_err;
  logic                  accept, drain;

  // Ready is a pure state decode so no path exists from out_ready.
  assign in_ready  = rst | (state != ST_FULL);
  assign out_valid = (state != ST_EMPTY);
  assign accept    = in_valid & in_ready;
  assign drain     = out_valid & out_ready;

  assign out_imm     = m_imm;
  assign out_lane_en = m_en;
  assign out_err     = m_err;

  // Skid FSM and storage; flush drops everything, including a same-cycle accept.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_EMPTY;
      m_imm <= '0;
      m_en  <= '0;
      m_err <= '0;
      k_imm <= '0;
      k_en  <= '0;
      k_err <= '0;
    end else if (flush) begin
      state <= ST_EMPTY;
    end else begin
      case (state)
        ST_EMPTY: begin
          if (accept) begin
            m_imm <= new_imm;
            m_en  <= in_lane_en;
            m_err <= new_err;
            state <= ST_ONE;
          end
        end
        ST_ONE: begin
          if (accept && drain) begin
            m_imm <= new_imm;
            m_en  <= in_lane_en;
            m_err <= new_err;
          end else if (accept) begin
            k_imm <= new_imm;
            k_en  <= in_lane_en;
            k_err <= new_err;
            state <= ST_FULL;
          end else if (drain) begin
            state <= ST_EMPTY;
          end
        end
        ST_FULL: begin
          if (drain) begin
            m_imm <= k_imm;
            m_en  <= k_en;
            m_err <= k_err;
            state <= ST_ONE;
          end
        end
        default: state <= ST_EMPTY;
      endcase
    end
  end

endmodule

// File: tb/tb_imm_pipe.sv
// tb_imm_pipe: directed bench for imm_pipe. Two instances share all inputs:
// one at XLEN=32 and one at XLEN=64, both with two lanes.
module tb_imm_pipe;

  logic         clk = 1'b0;
  logic         rst, flush, in_valid, out_ready;
  logic [63:0]  in_instr;
  logic [5:0]   in_sel;
  logic [1:0]   in_lane_en;

  logic         rdy32, val32, rdy64, val64;
  logic [63:0]  imm32;
  logic [127:0] imm64;
  logic [1:0]   en32, err32, en64, err64;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  imm_pipe #(.XLEN(32), .LANES(2)) dut32 (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(rdy32),
    .in_instr(in_instr), .in_sel(in_sel), .in_lane_en(in_lane_en),
    .out_valid(val32), .out_ready(out_ready),
    .out_imm(imm32), .out_lane_en(en32), .out_err(err32)
  );

  imm_pipe #(.XLEN(64), .LANES(2)) dut64 (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(rdy64),
    .in_instr(in_instr), .in_sel(in_sel), .in_lane_en(in_lane_en),
    .out_valid(val64), .out_ready(out_ready),
    .out_imm(imm64), .out_lane_en(en64), .out_err(err64)
  );

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic drv(input logic v, input logic [63:0] ins, input logic [5:0] sel,
                     input logic [1:0] en);
    in_valid   = v;
    in_instr   = ins;
    in_sel     = sel;
    in_lane_en = en;
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; out_ready = 1'b1;
    drv(1'b0, 64'h0, 6'h0, 2'b00);
    repeat (2) @(negedge clk);
    chk("rst_in_ready", rdy32, 1'b1);
    chk("rst_out_valid", val32, 1'b0);
    rst = 1'b0;
    @(negedge clk);
    chk("reset_imm32", imm32, 64'h0);
    chk("reset_imm64", imm64, 128'h0);
    chk("reset_err", err32, 2'b00);
    chk("reset_lane_en", en32, 2'b00);
    chk("reset_in_ready", rdy32, 1'b1);

    // Back-to-back format vectors with out_ready held high.
    drv(1'b1, {32'hFE000EE3, 32'hFFF00093}, {3'b010, 3'b000}, 2'b11);
    @(negedge clk);
    chk("ib_valid", val32, 1'b1);
    chk("ib_imm32", imm32, {32'hFFFFFFFC, 32'hFFFFFFFF});
    chk("ib_imm64", imm64, {64'hFFFFFFFFFFFFFFFC, 64'hFFFFFFFFFFFFFFFF});
    chk("ib_err", err32, 2'b00);
    chk("ib_lane_en", en32, 2'b11);

    drv(1'b1, {32'h0080006F, 32'h800000B7}, {3'b100, 3'b011}, 2'b11);
    @(negedge clk);
    chk("uj_imm32", imm32, {32'h00000008, 32'h80000000});
    chk("uj_imm64", imm64, {64'h0000000000000008, 64'hFFFFFFFF80000000});

    drv(1'b1, {32'h00B50533, 32'h000FD073}, {3'b101, 3'b110}, 2'b11);
    @(negedge clk);
    chk("zr_imm64", imm64, {64'h0, 64'h000000000000001F});
    chk("zr_imm32", imm32, {32'h0, 32'h0000001F});
    chk("zr_err", err64, 2'b00);

    drv(1'b1, {32'h00000000, 32'h00B50533}, {3'b111, 3'b101}, 2'b11);
    @(negedge clk);
    chk("ill_imm32", imm32, 64'h0);
    chk("ill_err", err32, 2'b10);

    drv(1'b1, {32'h00000000, 32'hFFF00093}, {3'b111, 3'b000}, 2'b01);
    @(negedge clk);
    chk("dis_imm32", imm32, {32'h0, 32'hFFFFFFFF});
    chk("dis_err", err32, 2'b00);
    chk("dis_lane_en", en32, 2'b01);

`ifdef IMM_PIPE_DECODE_EN
    drv(1'b1, {32'h00000000, 32'hFFF00093}, {3'b000, 3'b111}, 2'b01);
    @(negedge clk);
    chk("dec_imm32", imm32, {32'h0, 32'hFFFFFFFF});
    chk("dec_err", err32, 2'b00);
`endif

    drv(1'b0, 64'h0, 6'h0, 2'b00);
    @(negedge clk);
    chk("drained_valid", val32, 1'b0);

    // Stream A..D with the consumer stalled for three cycles.
    out_ready = 1'b0;
    drv(1'b1, {32'h00100093, 32'h00100093}, 6'h0, 2'b11);
    @(negedge clk);
    chk("st_a_ready", rdy32, 1'b1);
    chk("st_a_out", imm32, {32'h1, 32'h1});
    drv(1'b1, {32'h00200093, 32'h00200093}, 6'h0, 2'b11);
    @(negedge clk);
    chk("st_full_ready", rdy32, 1'b0);
    chk("st_hold_a1", imm32, {32'h1, 32'h1});
    drv(1'b1, {32'h00300093, 32'h00300093}, 6'h0, 2'b11);
    @(negedge clk);
    chk("st_full_ready2", rdy32, 1'b0);
    chk("st_hold_a2", imm32, {32'h1, 32'h1});
    chk("st_hold_valid", val32, 1'b1);
    out_ready = 1'b1;
    @(negedge clk);
    chk("st_b_out", imm32, {32'h2, 32'h2});
    chk("st_b_valid", val32, 1'b1);
    chk("st_b_ready", rdy32, 1'b1);
    @(negedge clk);
    chk("st_c_out", imm32, {32'h3, 32'h3});
    chk("st_c_valid", val32, 1'b1);
    drv(1'b1, {32'h00400093, 32'h00400093}, 6'h0, 2'b11);
    @(negedge clk);
    chk("st_d_out", imm32, {32'h4, 32'h4});
    chk("st_d_valid", val32, 1'b1);
    drv(1'b0, 64'h0, 6'h0, 2'b00);
    @(negedge clk);
    chk("st_end_valid", val32, 1'b0);

    // Flush while ONE, together with an offered bundle.
    out_ready = 1'b0;
    drv(1'b1, {32'h00100093, 32'h00100093}, 6'h0, 2'b11);
    @(negedge clk);
    chk("fl1_pre_valid", val32, 1'b1);
    drv(1'b1, {32'h07F00093, 32'h07F00093}, 6'h0, 2'b11);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    drv(1'b0, 64'h0, 6'h0, 2'b00);
    chk("fl1_valid", val32, 1'b0);
    chk("fl1_ready", rdy32, 1'b1);
    @(negedge clk);
    chk("fl1_no_ghost", val32, 1'b0);

    // Flush while FULL, together with an offered bundle.
    drv(1'b1, {32'h00100093, 32'h00100093}, 6'h0, 2'b11);
    @(negedge clk);
    drv(1'b1, {32'h00200093, 32'h00200093}, 6'h0, 2'b11);
    @(negedge clk);
    chk("fl2_full_ready", rdy32, 1'b0);
    drv(1'b1, {32'h07F00093, 32'h07F00093}, 6'h0, 2'b11);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    drv(1'b0, 64'h0, 6'h0, 2'b00);
    chk("fl2_valid", val32, 1'b0);
    chk("fl2_ready", rdy32, 1'b1);
    out_ready = 1'b1;
    @(negedge clk);
    chk("fl2_no_ghost", val32, 1'b0);

    // Reset pulse while FULL, then a fresh bundle.
    out_ready = 1'b0;
    drv(1'b1, {32'h00100093, 32'h00100093}, 6'h0, 2'b11);
    @(negedge clk);
    drv(1'b1, {32'h00200093, 32'h00200093}, 6'h0, 2'b11);
    @(negedge clk);
    chk("rs_full_ready", rdy32, 1'b0);
    drv(1'b0, 64'h0, 6'h0, 2'b00);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("rs_imm32", imm32, 64'h0);
    chk("rs_imm64", imm64, 128'h0);
    chk("rs_err", err32, 2'b00);
    chk("rs_lane_en", en64, 2'b00);
    chk("rs_valid", val32, 1'b0);
    chk("rs_ready", rdy32, 1'b1);
    out_ready = 1'b1;
    drv(1'b1, {32'h00300093, 32'h00300093}, 6'h0, 2'b11);
    @(negedge clk);
    chk("rs_new_valid", val32, 1'b1);
    chk("rs_new_imm", imm32, {32'h3, 32'h3});
    drv(1'b0, 64'h0, 6'h0, 2'b00);
    @(negedge clk);
    chk("rs_new_drained", val32, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
